// File: rtl/ice40_slave_spi_receiver_if.sv
// ice40_slave_spi_receiver_if: SB_SPI system-bus signals (strobe/ack register access).
interface ice40_slave_spi_receiver_if;
   logic [7:0] spi_data_out;
   logic       spi_ack;
   logic       spi_rw;
   logic [7:0] spi_reg_addr;
   logic       spi_strobe;
   logic [7:0] spi_data_in;
   modport master (input spi_data_out, spi_ack, output spi_rw, spi_reg_addr, spi_strobe, spi_data_in);
   modport slave (output spi_data_out, spi_ack, input spi_rw, spi_reg_addr, spi_strobe, spi_data_in);
endinterface

// File: rtl/ice40_slave_spi_receiver.sv
// ice40_slave_spi_receiver: configures SB_SPI as slave, polls SPISR, buffers SPIRXDR bytes into a FIFO stream.
// Optional sticky ROE reporting via SPI_RX_OVERRUN_EN.
module ice40_slave_spi_receiver #(
   parameter logic CPOL      = 1'b0,
   parameter logic CPHA      = 1'b0,
   parameter logic LSB_FIRST = 1'b1,
   parameter int   FIFO_AW   = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   ice40_slave_spi_receiver_if.master   bus,
   output logic [7:0]                   rx_data,
   output logic                         rx_valid,
   input  logic                         rx_ready,
   output logic                         cfg_done
`ifdef SPI_RX_OVERRUN_EN
   ,
   output logic                         overrun,
   input  logic                         overrun_clr
`endif
);
   localparam logic [7:0] SPICR0 = 8'h08, SPICR1 = 8'h09, SPICR2 = 8'h0A, SPISR = 8'h0C, SPIRXDR = 8'h0E;
   typedef enum logic [2:0] {CFG_CR0, CFG_CR1, CFG_CR2, POLL_SR, READ_RXDR} state_t;
   state_t state, state_n, next;
   logic strobe, strobe_n, rw, rw_n, cfg_n, w, bad, go, ack, push, pop, full;
   logic [7:0] addr, addr_n, din, din_n, a, d;
   logic [7:0] mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] wp, rp;
   logic [FIFO_AW:0] count;
   assign bus.spi_strobe   = strobe;
   assign bus.spi_rw       = rw;
   assign bus.spi_reg_addr = addr;
   assign bus.spi_data_in  = din;
   assign ack      = strobe && bus.spi_ack;
   assign full     = count[FIFO_AW];
   assign rx_valid = count != '0;
   assign rx_data  = rx_valid ? mem[rp] : 8'h00;
   assign pop      = rx_valid && rx_ready;
   always_comb begin
      a = 8'h00;
      w = 1'b0;
      d = 8'h00;
      bad = 1'b0;
      next = CFG_CR0;
      case (state)
         CFG_CR0:   begin a = SPICR0; w = 1'b1; next = CFG_CR1; end
         CFG_CR1:   begin a = SPICR1; w = 1'b1; d = 8'h80; next = CFG_CR2; end
         CFG_CR2:   begin a = SPICR2; w = 1'b1; d = {5'b00000, CPOL, CPHA, LSB_FIRST}; next = POLL_SR; end
         POLL_SR:   begin a = SPISR; next = (bus.spi_data_out[3] && !full) ? READ_RXDR : POLL_SR; end
         READ_RXDR: begin a = SPIRXDR; next = POLL_SR; end
         default:   bad = 1'b1;
      endcase
      // a full FIFO holds off the next status poll so a push can never overflow it
      go = !(state == POLL_SR && full);
      state_n = state;
      strobe_n = strobe;
      rw_n = rw;
      addr_n = addr;
      din_n = din;
      cfg_n = cfg_done || (ack && state == CFG_CR2);
      push = ack && state == READ_RXDR;
      if (bad) begin
         state_n = CFG_CR0;
         strobe_n = 1'b0;
      end else if (!strobe) begin
         if (go) {strobe_n, rw_n, addr_n, din_n} = {1'b1, w, a, d};
      end else if (bus.spi_ack) begin
         strobe_n = 1'b0;
         state_n = next;
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= CFG_CR0;
         strobe <= 1'b0;
         rw <= 1'b0;
         addr <= 8'h00;
         din <= 8'h00;
         cfg_done <= 1'b0;
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         state <= state_n;
         strobe <= strobe_n;
         rw <= rw_n;
         addr <= addr_n;
         din <= din_n;
         cfg_done <= cfg_n;
         wp <= wp + FIFO_AW'(push);
         rp <= rp + FIFO_AW'(pop);
         count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= bus.spi_data_out;
`ifdef SPI_RX_OVERRUN_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) overrun <= 1'b0;
      else overrun <= (ack && state == POLL_SR && bus.spi_data_out[1]) || (overrun && !overrun_clr);
`endif
endmodule

// File: tb/tb_ice40_slave_spi_receiver.sv
// tb_ice40_slave_spi_receiver: directed bench with a 1-cycle-latency SB_SPI bus responder.
module tb_ice40_slave_spi_receiver;
   logic clk = 1'b0, reset_n = 1'b0, rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic rx_valid, cfg_done;
`ifdef SPI_RX_OVERRUN_EN
   logic overrun, overrun_clr = 1'b0;
`endif
   int checks = 0, fails = 0;
   logic [7:0] rxq[$];
   logic [16:0] txlog[$];
   logic roe = 1'b0;
   ice40_slave_spi_receiver_if bus();
   ice40_slave_spi_receiver dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.master), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .cfg_done(cfg_done)
`ifdef SPI_RX_OVERRUN_EN
      , .overrun(overrun), .overrun_clr(overrun_clr)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bus.spi_ack <= 1'b0;
         bus.spi_data_out <= 8'h00;
      end else begin
         if (bus.spi_strobe && bus.spi_ack) begin
            txlog.push_back({bus.spi_rw, bus.spi_reg_addr, bus.spi_data_in});
            if (!bus.spi_rw && bus.spi_reg_addr == 8'h0E && rxq.size() != 0) void'(rxq.pop_front());
         end
         bus.spi_ack <= bus.spi_strobe && !bus.spi_ack;
         bus.spi_data_out <= bus.spi_reg_addr == 8'h0C ? {4'b0000, rxq.size() != 0, 1'b0, roe, 1'b0} :
                             bus.spi_reg_addr == 8'h0E ? (rxq.size() != 0 ? rxq[0] : 8'hEE) : 8'h00;
      end
   task automatic wait_log(input int n);
      for (int i = 0; i < 200 && txlog.size() < n; i++) @(negedge clk);
   endtask
   task automatic test_reset;
      logic [16:0] exp [4] = '{{1'b1, 8'h08, 8'h00}, {1'b1, 8'h09, 8'h80}, {1'b1, 8'h0A, 8'h01}, {1'b0, 8'h0C, 8'h00}};
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.spi_strobe, bus.spi_rw, bus.spi_reg_addr, bus.spi_data_in, rx_valid, rx_data, cfg_done} !== 28'h0) begin
         fails++;
         $display("FAIL reset_outputs: got strobe=%b rw=%b addr=%h din=%h valid=%b data=%h cfg=%b expected all 0",
                  bus.spi_strobe, bus.spi_rw, bus.spi_reg_addr, bus.spi_data_in, rx_valid, rx_data, cfg_done);
      end
`ifdef SPI_RX_OVERRUN_EN
      checks++;
      if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`endif
      txlog.delete();
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.spi_strobe, bus.spi_reg_addr} !== {1'b1, 8'h08}) begin
         fails++;
         $display("FAIL first_strobe: got strobe=%b addr=%h expected 1/08", bus.spi_strobe, bus.spi_reg_addr);
      end
      wait_log(4);
      checks++;
      if (txlog.size() < 4) begin
         fails++;
         $display("FAIL cfg_sequence_len: got %0d transactions expected >=4", txlog.size());
      end else
         for (int i = 0; i < 4; i++) begin
            checks++;
            if ((i < 3 ? txlog[i] : {txlog[i][16:8], 8'h00}) !== exp[i]) begin
               fails++;
               $display("FAIL cfg_txn%0d: got %h expected %h", i, txlog[i], exp[i]);
            end
         end
      checks++;
      if (cfg_done !== 1'b1) begin fails++; $display("FAIL cfg_done: got %b expected 1", cfg_done); end
   endtask
   task automatic test_no_data;
      int bad = 0, vld = 0;
      txlog.delete();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rx_valid) vld++;
      end
      foreach (txlog[i]) if (txlog[i][16:8] !== {1'b0, 8'h0C}) bad++;
      checks++;
      if (vld != 0) begin fails++; $display("FAIL idle_valid: got %0d valid cycles expected 0", vld); end
      checks++;
      if (bad != 0 || txlog.size() == 0) begin
         fails++;
         $display("FAIL idle_polls: got %0d non-SR of %0d transactions expected 0 of >0", bad, txlog.size());
      end
   endtask
   task automatic test_single;
      rx_ready = 1'b1;
      rxq.push_back(8'hA5);
      for (int i = 0; i < 60 && !rx_valid; i++) @(negedge clk);
      checks++;
      if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin
         fails++;
         $display("FAIL single_byte: got valid=%b data=%h expected 1/a5", rx_valid, rx_data);
      end
      @(negedge clk);
      checks++;
      if ({rx_valid, rx_data} !== 9'h000) begin
         fails++;
         $display("FAIL single_pulse: got valid=%b data=%h expected 0/00", rx_valid, rx_data);
      end
   endtask
   task automatic test_fill;
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int rd = 0, strobes = 0;
      bit polled = 0;
      rx_ready = 1'b0;
      txlog.delete();
      foreach (exp[i]) rxq.push_back(exp[i]);
      rxq.push_back(8'h55);
      repeat (80) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.spi_strobe) strobes++;
      end
      foreach (txlog[i]) if (txlog[i][16:8] == {1'b0, 8'h0E}) rd++;
      checks++;
      if (strobes != 0 || rxq.size() != 1) begin
         fails++;
         $display("FAIL full_stall: got %0d strobes, %0d pending expected 0 strobes, 1 pending", strobes, rxq.size());
      end
      checks++;
      if (rd != 4) begin fails++; $display("FAIL full_reads: got %0d RXDR reads expected 4", rd); end
      rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rx_valid, rx_data} !== {1'b1, exp[i]}) begin
            fails++;
            $display("FAIL drain%0d: got valid=%b data=%h expected 1/%h", i, rx_valid, rx_data, exp[i]);
         end
         @(negedge clk);
         if (bus.spi_strobe) polled = 1;
      end
      checks++;
      if (!polled) begin fails++; $display("FAIL poll_resume: got no strobe during drain expected strobe"); end
      for (int i = 0; i < 60 && !rx_valid; i++) @(negedge clk);
      checks++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h55}) begin
         fails++;
         $display("FAIL after_drain: got valid=%b data=%h expected 1/55", rx_valid, rx_data);
      end
      @(negedge clk);
   endtask
   task automatic test_reset_mid;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 40 && !(bus.spi_strobe && bus.spi_reg_addr == 8'h09); i++) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.spi_strobe, bus.spi_reg_addr, cfg_done} !== 10'h0) begin
         fails++;
         $display("FAIL async_reset: got strobe=%b addr=%h cfg=%b expected 0/00/0", bus.spi_strobe, bus.spi_reg_addr, cfg_done);
      end
      @(negedge clk);
      txlog.delete();
      reset_n = 1'b1;
      wait_log(1);
      checks++;
      if (txlog.size() == 0 || txlog[0] !== {1'b1, 8'h08, 8'h00}) begin
         fails++;
         $display("FAIL restart_cr0: got %0d txns first=%h expected first 108_00", txlog.size(), txlog.size() ? txlog[0] : 17'h0);
      end
      wait_log(4);
   endtask
`ifdef SPI_RX_OVERRUN_EN
   task automatic wait_sr_ack;
      for (int i = 0; i < 40 && !(bus.spi_strobe && bus.spi_ack && bus.spi_reg_addr == 8'h0C); i++) @(negedge clk);
   endtask
   task automatic test_overrun;
      roe = 1'b1;
      repeat (4) @(negedge clk);
      wait_sr_ack();
      @(posedge clk);
      #1;
      checks++;
      if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", overrun); end
      roe = 1'b0;
      repeat (6) @(negedge clk);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clr: got %b expected 0", overrun); end
      roe = 1'b1;
      repeat (4) @(negedge clk);
      wait_sr_ack();
      overrun_clr = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set_wins: got %b expected 1", overrun); end
      @(negedge clk);
      overrun_clr = 1'b0;
      roe = 1'b0;
   endtask
`endif
   initial begin
      test_reset();
      test_no_data();
      test_single();
      test_fill();
      test_reset_mid();
`ifdef SPI_RX_OVERRUN_EN
      test_overrun();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
